// File: rtl/controller_sr04.sv
// ---------------------------------------------------------------------------
// controller_sr04
//
// Measurement controller for an HC-SR04 ultrasonic ranging sensor.
// Each measurement runs four steps:
//    1. A start request (btn_r) fires a 10 us trigger pulse.
//    2. The controller waits for the sensor's echo to rise.
//    3. It times the echo-high width in 1 us ticks.
//    4. It converts that width to whole centimetres (truncating, 1 cm per
//       US_PER_CM us), using a wrap counter rather than a divider.
//
// The result is held on 'distance' until the next measurement completes.
// If the echo never rises, or stays high too long, the result is 24'hFFFFFF.
//
// Optional feature, enabled by defining SR04_AUTO_TRIG_EN:
//    A period counter also starts a measurement every AUTO_PERIOD_US ticks
//    while idle. btn_r still works, and every start restarts the period.
//
// Ports:
//    clk        in   system clock (100 MHz nominal)
//    rst        in   asynchronous active-high reset
//    btn_r      in   start request, single-clk pulse (debounced upstream)
//    i_tick_1us in   one-clk strobe every 1 us, synchronous to clk
//    echo       in   sensor echo pin, asynchronous
//    o_trigger  out  sensor trigger pulse
//    distance   out  last result in cm (24'hFFFFFF on timeout)
// ---------------------------------------------------------------------------
module controller_sr04 #(
   parameter int TRIG_US    = 10,
   parameter int US_PER_CM  = 58,
   parameter int TIMEOUT_US = 30000
`ifdef SR04_AUTO_TRIG_EN
   ,
   parameter int AUTO_PERIOD_US = 60000
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_r,
   input  logic        i_tick_1us,
   input  logic        echo,
   output logic        o_trigger,
   output logic [23:0] distance
);

   // The shared tick counter times the trigger pulse, the wait for the
   // echo, and the total echo width, so it must hold the larger limit.
   localparam int TMAX = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int UW   = $clog2(US_PER_CM + 1);

   localparam logic [TW-1:0] TRIG_LAST    = TW'(TRIG_US - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_US - 1);
   localparam logic [UW-1:0] US_LAST      = UW'(US_PER_CM - 1);

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, DONE} state_t;

   state_t        state, state_next;
   logic [TW-1:0] tick_cnt, tick_next;
   logic [UW-1:0] us_cnt, us_next;
   logic [23:0]   cm_cnt, cm_next;
   logic          timeout_flag, timeout_next;
   logic [23:0]   dist_next;
   logic          echo_meta, echo_sync, echo_prev;
   logic          echo_rise, echo_fall;
   logic          start_req;

   // Bring the asynchronous echo pin into the clock domain.
   // The extra registered copy provides edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         echo_meta <= 1'b0;
         echo_sync <= 1'b0;
         echo_prev <= 1'b0;
      end else begin
         echo_meta <= echo;
         echo_sync <= echo_meta;
         echo_prev <= echo_sync;
      end
   end

   assign echo_rise = echo_sync & ~echo_prev;
   assign echo_fall = ~echo_sync & echo_prev;

`ifdef SR04_AUTO_TRIG_EN
   localparam int PW = $clog2(AUTO_PERIOD_US + 1);
   localparam logic [PW-1:0] PERIOD_FULL = PW'(AUTO_PERIOD_US);

   logic [PW-1:0] period_cnt;

   // Free-running period timer.
   // It saturates at the full period, so a period that expires mid-measurement
   // still fires as soon as the FSM returns to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_cnt <= '0;
      end else if ((state == IDLE) && start_req) begin
         period_cnt <= '0;
      end else if (i_tick_1us && (period_cnt != PERIOD_FULL)) begin
         period_cnt <= period_cnt + PW'(1);
      end
   end

   assign start_req = btn_r | (period_cnt == PERIOD_FULL);
`else
   assign start_req = btn_r;
`endif

   // State and datapath registers.
   // o_trigger is registered from the next state, so it is high exactly
   // while the FSM sits in TRIG.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         tick_cnt     <= '0;
         us_cnt       <= '0;
         cm_cnt       <= '0;
         timeout_flag <= 1'b0;
         distance     <= '0;
         o_trigger    <= 1'b0;
      end else begin
         state        <= state_next;
         tick_cnt     <= tick_next;
         us_cnt       <= us_next;
         cm_cnt       <= cm_next;
         timeout_flag <= timeout_next;
         distance     <= dist_next;
         o_trigger    <= (state_next == TRIG);
      end
   end

   // Next-state and datapath logic.
   // Centimetres are accumulated by wrapping the us counter every
   // US_PER_CM ticks, which truncates any partial centimetre.
   always_comb begin
      state_next   = state;
      tick_next    = tick_cnt;
      us_next      = us_cnt;
      cm_next      = cm_cnt;
      timeout_next = timeout_flag;
      dist_next    = distance;
      case (state)
         IDLE: begin
            tick_next    = '0;
            timeout_next = 1'b0;
            if (start_req) begin
               state_next = TRIG;
            end
         end
         TRIG: begin
            if (i_tick_1us) begin
               if (tick_cnt == TRIG_LAST) begin
                  tick_next  = '0;
                  state_next = WAIT_ECHO;
               end else begin
                  tick_next = tick_cnt + TW'(1);
               end
            end
         end
         WAIT_ECHO: begin
            if (echo_rise) begin
               tick_next  = '0;
               us_next    = '0;
               cm_next    = '0;
               state_next = MEASURE;
            end else if (i_tick_1us) begin
               if (tick_cnt == TIMEOUT_LAST) begin
                  timeout_next = 1'b1;
                  state_next   = DONE;
               end else begin
                  tick_next = tick_cnt + TW'(1);
               end
            end
         end
         MEASURE: begin
            if (echo_fall) begin
               state_next = DONE;
            end else if (i_tick_1us) begin
               if (us_cnt == US_LAST) begin
                  us_next = '0;
                  cm_next = cm_cnt + 24'd1;
               end else begin
                  us_next = us_cnt + UW'(1);
               end
               if (tick_cnt == TIMEOUT_LAST) begin
                  timeout_next = 1'b1;
                  state_next   = DONE;
               end else begin
                  tick_next = tick_cnt + TW'(1);
               end
            end
         end
         DONE: begin
            dist_next  = timeout_flag ? 24'hFFFFFF : cm_cnt;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_controller_sr04.sv
// ---------------------------------------------------------------------------
// tb_controller_sr04
//
// Directed self-checking bench for controller_sr04.
//
// The 1 us tick is compressed to one strobe every 5 clocks, and the timeout
// is shortened to 1000 ticks, so the timeout cases stay short. All widths
// below are expressed in ticks.
//
// Inputs change on the falling clock edge, and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_controller_sr04;

   localparam int TIMEOUT = 1000;

   logic        clk;
   logic        rst;
   logic        btn_r;
   logic        i_tick_1us;
   logic        echo;
   logic        o_trigger;
   logic [23:0] distance;

   int          total;
   int          bad;
   logic [23:0] heldDist;
   int          tickDiv;

   controller_sr04 #(
      .TRIG_US(10),
      .US_PER_CM(58),
      .TIMEOUT_US(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_r(btn_r),
      .i_tick_1us(i_tick_1us),
      .echo(echo),
      .o_trigger(o_trigger),
      .distance(distance)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Tick strobe: one clock wide, every 5 clocks.
   // It changes 2 ns after the rising edge so it never races the DUT or the
   // stimulus applied on the falling edge.
   initial begin
      i_tick_1us = 1'b0;
      tickDiv    = 0;
      forever begin
         @(posedge clk);
         #2;
         tickDiv    = (tickDiv == 4) ? 0 : tickDiv + 1;
         i_tick_1us = (tickDiv == 4);
      end
   end

   // Safety net in case the run stalls
   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [23:0] observed, input logic [23:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic waitClks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns on the falling edge after the n-th tick has been consumed.
   // A tick pending at the current falling edge counts as the first one.
   task automatic waitTicks(input int n);
      repeat (n) begin
         while (!i_tick_1us) @(negedge clk);
         @(negedge clk);
      end
   endtask

   // Start pulse deliberately coincides with a tick, which must not count
   // toward the trigger width.
   task automatic pressBtn();
      while (!i_tick_1us) @(negedge clk);
      btn_r = 1'b1;
      @(negedge clk);
      btn_r = 1'b0;
   endtask

   // Called right after a tick was consumed, so this pulse spans a tick-free
   // edge and does not disturb tick counting.
   task automatic pokeBtn();
      btn_r = 1'b1;
      @(negedge clk);
      btn_r = 1'b0;
   endtask

   // One full measurement: trigger, gap, echo of widthUs ticks, result.
   // With poke set, start requests are also issued during TRIG and MEASURE.
   task automatic applyStimulus(input int gapUs, input int widthUs, input logic [23:0] expected,
                                input bit poke, input string tag);
      pressBtn();
      checkOutput({tag, "_trigRise"}, {23'd0, o_trigger}, 24'd1);
      if (poke) begin
         waitTicks(3);
         pokeBtn();
         waitTicks(6);
      end else begin
         waitTicks(9);
      end
      checkOutput({tag, "_trigHold"}, {23'd0, o_trigger}, 24'd1);
      waitTicks(1);
      checkOutput({tag, "_trigFall"}, {23'd0, o_trigger}, 24'd0);
      waitTicks(gapUs);
      echo = 1'b1;
      if (poke) begin
         waitTicks(20);
         pokeBtn();
         waitTicks(widthUs - 20);
      end else begin
         waitTicks(widthUs);
      end
      checkOutput({tag, "_heldDuring"}, distance, heldDist);
      echo = 1'b0;
      waitClks(4);
      checkOutput({tag, "_result"}, distance, expected);
      waitClks(20);
      checkOutput({tag, "_resultHeld"}, distance, expected);
      heldDist = expected;
   endtask

   initial begin
      int trigHighs;
      total    = 0;
      bad      = 0;
      heldDist = 24'd0;
      rst      = 1'b1;
      btn_r    = 1'b0;
      echo     = 1'b0;

      // Reset state
      #20;
      checkOutput("rstTrig", {23'd0, o_trigger}, 24'd0);
      checkOutput("rstDist", distance, 24'd0);
      rst = 1'b0;
      waitClks(10);
      checkOutput("idleTrig", {23'd0, o_trigger}, 24'd0);
      checkOutput("idleDist", distance, 24'd0);

      // Basic measurement and truncation boundaries
      applyStimulus(15, 580, 24'd10, 1'b0, "basic580");
      applyStimulus(15, 57, 24'd0, 1'b0, "trunc57");
      applyStimulus(15, 58, 24'd1, 1'b0, "trunc58");
      applyStimulus(15, 115, 24'd1, 1'b0, "trunc115");
      applyStimulus(15, 116, 24'd2, 1'b0, "trunc116");

      // Timeout waiting for the echo to rise
      pressBtn();
      waitTicks(10);
      checkOutput("noEcho_trigFall", {23'd0, o_trigger}, 24'd0);
      waitTicks(TIMEOUT - 1);
      checkOutput("noEcho_beforeLimit", distance, 24'd2);
      waitTicks(1);
      waitClks(2);
      checkOutput("noEcho_timeout", distance, 24'hFFFFFF);
      heldDist = 24'hFFFFFF;
      applyStimulus(5, 58, 24'd1, 1'b0, "afterNoEcho");

      // Echo held high well beyond the limit
      pressBtn();
      waitTicks(10);
      waitTicks(5);
      echo = 1'b1;
      waitTicks(TIMEOUT - 1);
      checkOutput("longEcho_beforeLimit", distance, 24'd1);
      waitTicks(1);
      waitClks(2);
      checkOutput("longEcho_timeout", distance, 24'hFFFFFF);
      waitTicks(500);
      echo = 1'b0;
      waitClks(10);
      checkOutput("longEcho_held", distance, 24'hFFFFFF);
      checkOutput("longEcho_trig", {23'd0, o_trigger}, 24'd0);
      heldDist = 24'hFFFFFF;

      // Start requests while busy are ignored: one trigger, one result
      applyStimulus(10, 116, 24'd2, 1'b1, "busy");
      trigHighs = 0;
      repeat (300) begin
         @(negedge clk);
         if (o_trigger) trigHighs++;
      end
      checkOutput("busy_noRetrigger", 24'(trigHighs), 24'd0);
      checkOutput("busy_resultStable", distance, 24'd2);

      // Reset in the middle of an echo
      pressBtn();
      waitTicks(10);
      waitTicks(5);
      echo = 1'b1;
      waitTicks(100);
      rst = 1'b1;
      #1;
      checkOutput("midRst_trig", {23'd0, o_trigger}, 24'd0);
      checkOutput("midRst_dist", distance, 24'd0);
      waitClks(2);
      echo = 1'b0;
      waitClks(2);
      rst = 1'b0;
      waitClks(5);
      checkOutput("afterRst_dist", distance, 24'd0);
      heldDist = 24'd0;
      applyStimulus(15, 580, 24'd10, 1'b0, "afterRst580");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
